// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : core_seq_ctrl
//  Purpose  : Multi-cycle control FSM for the piRISC core. Sequences the
//             datapath through FETCH, DECODE, EXEC, MEM and WB. It also
//             handshakes with a stalling instruction/data memory, drives every
//             datapath write enable and mux select, and counts retired
//             instructions. The halt word 32'hFFFFFFFF stops execution.
//  Ports    : clk, reset (sync, active-high)
//             go_contr         - start request, sampled only in IDLE
//             ir               - instruction register (valid from DECODE)
//             mem_ready        - memory access complete this cycle
//             branch_taken     - ALU compare result, valid in EXEC
//             pc_we/pc_sel     - PC write enable / source (0 +4, 1 target, 2 init)
//             pc_init          - RESET_PC constant
//             ir_we            - capture fetched word into IR
//             mem_req/mem_we   - memory request / store qualifier
//             rf_we/wb_sel     - RF write enable / source (0 ALU, 1 mem, 2 PC+4)
//             alu_src_imm      - ALU B operand from immediate
//             view_alu         - one-cycle pulse after EXEC
//             state, halted, err, instret - status
//  Options  : CORE_SEQ_ILLEGAL_TRAP_EN - unknown opcode halts with err set
//             instead of executing as a NOP.
//  Revision : 1.0 - initial release
// ============================================================================
module core_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go_contr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [31:0] pc_init,
  output logic        ir_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_imm,
  output logic        view_alu,
  output logic [2:0]  state,
  output logic        halted,
  output logic        err,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0]  c_op_r     = 7'b0110011;
  localparam logic [6:0]  c_op_ialu  = 7'b0010011;
  localparam logic [6:0]  c_op_load  = 7'b0000011;
  localparam logic [6:0]  c_op_store = 7'b0100011;
  localparam logic [6:0]  c_op_lui   = 7'b0110111;
  localparam logic [6:0]  c_op_br    = 7'b1100011;
  localparam logic [6:0]  c_op_jal   = 7'b1101111;
  localparam logic [31:0] c_halt_w   = 32'hFFFF_FFFF;
  // The abort fires on the waiting cycle that brings the count to MEM_TIMEOUT.
  localparam logic [7:0]  c_tmo_last = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait_cnt;
  logic        r_err;
  logic        r_view_alu;
  logic [31:0] r_instret;
  logic        w_retire;
  logic        w_set_err;
  logic        w_tmo;

  logic w_is_r, w_is_ialu, w_is_load, w_is_store, w_is_lui, w_is_br, w_is_jal;
  logic w_known;

  assign w_is_r     = (ir[6:0] == c_op_r);
  assign w_is_ialu  = (ir[6:0] == c_op_ialu);
  assign w_is_load  = (ir[6:0] == c_op_load);
  assign w_is_store = (ir[6:0] == c_op_store);
  assign w_is_lui   = (ir[6:0] == c_op_lui);
  assign w_is_br    = (ir[6:0] == c_op_br);
  assign w_is_jal   = (ir[6:0] == c_op_jal);
  assign w_known    = w_is_r | w_is_ialu | w_is_load | w_is_store |
                      w_is_lui | w_is_br | w_is_jal;
  assign w_tmo      = (r_wait_cnt == c_tmo_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_err      <= 1'b0;
      r_view_alu <= 1'b0;
      r_instret  <= 32'd0;
    end else begin
      r_state    <= w_next;
      // Counts only consecutive stalled cycles of one access; any completed
      // access or any other state clears it, so each FETCH/MEM starts at 0.
      if (((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
      r_err      <= r_err | w_set_err;
      r_view_alu <= (r_state == S_EXEC);
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    ir_we       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 2'd0;
    alu_src_imm = 1'b0;
    w_retire    = 1'b0;
    w_set_err   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (go_contr) w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_tmo) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_DECODE: begin
        if (ir == c_halt_w) begin
          w_next = S_HALT;
        end else begin
`ifdef CORE_SEQ_ILLEGAL_TRAP_EN
          if (!w_known) begin
            w_set_err = 1'b1;
            w_next    = S_HALT;
          end else begin
            w_next = S_EXEC;
          end
`else
          w_next = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        alu_src_imm = w_is_ialu | w_is_load | w_is_store | w_is_lui;
        if (w_is_br) begin
          pc_we    = 1'b1;
          pc_sel   = branch_taken ? 2'd1 : 2'd0;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else if (w_known) begin
          w_next = S_WB;
        end else begin
          // Unknown opcode executes as a NOP (unreachable with the trap on).
          pc_we    = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = w_is_store;
        if (mem_ready) begin
          if (w_is_store) begin
            pc_we    = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_tmo) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        wb_sel   = w_is_load ? 2'd1 : (w_is_jal ? 2'd2 : 2'd0);
        pc_we    = 1'b1;
        pc_sel   = w_is_jal ? 2'd1 : 2'd0;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Reset overrides everything, even an access in flight, and reloads PC.
    if (reset) begin
      w_next      = S_IDLE;
      pc_we       = 1'b1;
      pc_sel      = 2'd2;
      ir_we       = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      rf_we       = 1'b0;
      wb_sel      = 2'd0;
      alu_src_imm = 1'b0;
      w_retire    = 1'b0;
      w_set_err   = 1'b0;
    end
  end

  assign pc_init  = RESET_PC;
  assign state    = r_state;
  assign halted   = (r_state == S_HALT) && !reset;
  assign err      = r_err;
  assign view_alu = r_view_alu;
  assign instret  = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_core_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_seq_ctrl
//  Purpose  : Self-checking bench for core_seq_ctrl. Plays the memory and
//             ALU around the controller, runs directed and random programs,
//             and compares every cycle against expectations derived from the
//             instruction class of each word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, go_contr, mem_ready, branch_taken;
  logic [31:0] ir;
  logic        pc_we, ir_we, mem_req, mem_we, rf_we, alu_src_imm, view_alu;
  logic        halted, err;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] pc_init, instret;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_instret;
  int          rf_pulses;

  localparam int K_R = 0, K_IALU = 1, K_LOAD = 2, K_STORE = 3, K_LUI = 4,
                 K_BR = 5, K_JAL = 6, K_ILL = 7, K_HALTW = 8;

  core_seq_ctrl dut (
    .clk(clk), .reset(reset), .go_contr(go_contr), .ir(ir),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_init(pc_init), .ir_we(ir_we),
    .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_src_imm(alu_src_imm), .view_alu(view_alu), .state(state),
    .halted(halted), .err(err), .instret(instret)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rf_we) rf_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cls(input logic [31:0] w);
    if (w == 32'hFFFF_FFFF) return K_HALTW;
    case (w[6:0])
      7'b0110011: return K_R;
      7'b0010011: return K_IALU;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0110111: return K_LUI;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] make_word(input int c);
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case (c)
      K_R:     op = 7'b0110011;
      K_IALU:  op = 7'b0010011;
      K_LOAD:  op = 7'b0000011;
      K_STORE: op = 7'b0100011;
      K_LUI:   op = 7'b0110111;
      K_BR:    op = 7'b1100011;
      K_JAL:   op = 7'b1101111;
      default: op = 7'b1111111;
    endcase
    r[6:0] = op;
    if (r == 32'hFFFF_FFFF) r[31] = 1'b0;
    return r;
  endfunction

  // Reset, then leave IDLE with a one-cycle go pulse; expects FETCH next.
  task automatic start_run();
    reset = 1'b1; go_contr = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; ir = 32'd0;
    step();
    step();
    reset = 1'b0; go_contr = 1'b1; #1;
    chk("start_idle", state, 0);
    step();
    go_contr = 1'b0;
    exp_instret = 32'd0;
    rf_pulses = 0;
  endtask

  // Executes one instruction from FETCH onward with the given stalls.
  task automatic do_instr(input logic [31:0] w, input int flat, input int mlat, input logic taken);
    int  c;
    logic imm, ldst;
    c = cls(w);
    for (int i = 0; i < flat; i++) begin
      mem_ready = 1'b0; #1;
      chk("fetch_state", state, 1);
      chk("fetch_req", mem_req, 1);
      chk("fetch_irwe", ir_we, 0);
      step();
    end
    mem_ready = 1'b1; #1;
    chk("fetch_state", state, 1);
    chk("fetch_irwe", ir_we, 1);
    chk("fetch_we", mem_we, 0);
    chk("fetch_pcwe", pc_we, 0);
    step();
    ir = w; mem_ready = 1'($urandom_range(0, 1)); #1;
    chk("dec_state", state, 2);
    chk("dec_req", mem_req, 0);
    chk("dec_pcwe", pc_we, 0);
    chk("dec_view", view_alu, 0);
    step();
    mem_ready = 1'b0;
    if (c == K_HALTW) begin
      #1;
      chk("halt_state", state, 6);
      chk("halt_flag", halted, 1);
      chk("halt_instret", instret, exp_instret);
      return;
    end
`ifdef CORE_SEQ_ILLEGAL_TRAP_EN
    if (c == K_ILL) begin
      #1;
      chk("trap_state", state, 6);
      chk("trap_err", err, 1);
      chk("trap_pcwe", pc_we, 0);
      chk("trap_instret", instret, exp_instret);
      return;
    end
`endif
    imm  = (c == K_IALU) || (c == K_LOAD) || (c == K_STORE) || (c == K_LUI);
    ldst = (c == K_LOAD) || (c == K_STORE);
    branch_taken = taken; mem_ready = 1'($urandom_range(0, 1)); #1;
    chk("exec_state", state, 3);
    chk("exec_imm", alu_src_imm, imm);
    chk("exec_rfwe", rf_we, 0);
    chk("exec_req", mem_req, 0);
    chk("exec_pcwe", pc_we, (c == K_BR) || (c == K_ILL));
    if (c == K_BR) chk("exec_pcsel", pc_sel, taken ? 1 : 0);
    if (c == K_ILL) chk("exec_pcsel", pc_sel, 0);
    step();
    chk("view_alu", view_alu, 1);
    if (c == K_BR || c == K_ILL) begin
      exp_instret++;
      chk("instret", instret, exp_instret);
      return;
    end
    if (ldst) begin
      for (int i = 0; i < mlat; i++) begin
        mem_ready = 1'b0; #1;
        chk("mem_state", state, 4);
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, c == K_STORE);
        chk("mem_pcwe", pc_we, 0);
        step();
      end
      mem_ready = 1'b1; #1;
      chk("mem_state", state, 4);
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, c == K_STORE);
      chk("mem_pcwe", pc_we, c == K_STORE);
      if (c == K_STORE) chk("mem_pcsel", pc_sel, 0);
      step();
      if (c == K_STORE) begin
        exp_instret++;
        chk("instret", instret, exp_instret);
        return;
      end
    end
    mem_ready = 1'($urandom_range(0, 1)); #1;
    chk("wb_state", state, 5);
    chk("wb_rfwe", rf_we, 1);
    chk("wb_sel", wb_sel, (c == K_LOAD) ? 1 : ((c == K_JAL) ? 2 : 0));
    chk("wb_pcwe", pc_we, 1);
    chk("wb_pcsel", pc_sel, (c == K_JAL) ? 1 : 0);
    chk("wb_req", mem_req, 0);
    step();
    exp_instret++;
    chk("instret", instret, exp_instret);
  endtask

  initial begin
    int n;
    int c;
    logic [31:0] w;
    // ---- reset state ----
    reset = 1'b1; go_contr = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; ir = 32'd0;
    step();
    chk("rst_state", state, 0);
    chk("rst_pcwe", pc_we, 1);
    chk("rst_pcsel", pc_sel, 2);
    chk("rst_req", mem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_instret", instret, 0);
    chk("rst_view", view_alu, 0);
    chk("pc_init", pc_init, 32'h0);
    reset = 1'b0; go_contr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_wait", state, 0);
      chk("idle_pcwe", pc_we, 0);
    end

    // ---- ADDI then halt ----
    start_run();
    do_instr(32'h0010_0093, 0, 0, 1'b0);
    do_instr(32'hFFFF_FFFF, 0, 0, 1'b0);
    chk("t1_rf_pulses", rf_pulses, 1);
    chk("t1_instret", instret, 1);
    go_contr = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_absorb", state, 6);
      chk("halt_req", mem_req, 0);
    end

    // ---- LOAD with 3 stall cycles, BEQ taken / not taken, JAL, STORE ----
    start_run();
    do_instr(make_word(K_LOAD), 1, 3, 1'b0);
    do_instr(make_word(K_BR), 0, 0, 1'b1);
    do_instr(make_word(K_BR), 2, 0, 1'b0);
    do_instr(make_word(K_JAL), 0, 0, 1'b0);
    do_instr(make_word(K_STORE), 0, 2, 1'b0);
    do_instr(32'hFFFF_FFFF, 0, 0, 1'b0);
    chk("dir_err", err, 0);

    // ---- random program ----
    start_run();
    for (int k = 0; k < 40; k++) begin
`ifdef CORE_SEQ_ILLEGAL_TRAP_EN
      c = $urandom_range(0, 6);
`else
      c = $urandom_range(0, 7);
`endif
      w = make_word(c);
      do_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    do_instr(32'hFFFF_FFFF, 1, 0, 1'b0);
    chk("rnd_err", err, 0);

    // ---- fetch timeout ----
    start_run();
    mem_ready = 1'b0;
    n = 0;
    while (state == 3'd1 && n < 300) begin
      n++;
      step();
    end
    chk("tmo_wait_cycles", n, 255);
    chk("tmo_state", state, 6);
    chk("tmo_err", err, 1);
    chk("tmo_req", mem_req, 0);
    chk("tmo_halted", halted, 1);

    // ---- reset during MEM of a STORE ----
    start_run();
    do_instr(32'h0010_0093, 0, 0, 1'b0);
    mem_ready = 1'b1; #1;
    step();
    ir = make_word(K_STORE); mem_ready = 1'b0;
    step();
    step();
    chk("rmem_state", state, 4);
    chk("rmem_we", mem_we, 1);
    reset = 1'b1;
    step();
    chk("rmem_state_after", state, 0);
    chk("rmem_req", mem_req, 0);
    chk("rmem_instret", instret, 0);
    chk("rmem_pcwe", pc_we, 1);
    chk("rmem_pcsel", pc_sel, 2);
    reset = 1'b0;

    // ---- opcode 7'b1111111, not the halt word ----
    start_run();
    do_instr(32'h0000_007F, 0, 0, 1'b0);
`ifdef CORE_SEQ_ILLEGAL_TRAP_EN
    chk("ill_halted", halted, 1);
    chk("ill_instret", instret, 0);
`else
    chk("ill_err", err, 0);
    chk("ill_instret", instret, 1);
    do_instr(32'hFFFF_FFFF, 0, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
